// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM-state constants for the sequential ALU.
// Also decides which opcodes go through the iterative multiply/divide unit.
package seq_alu_pkg;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_MUL  = 3'b011;
   localparam logic [2:0] OP_DIVU = 3'b100;
   localparam logic [2:0] OP_REMU = 3'b101;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   function automatic logic is_multi(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider sharing one datapath.
// The result outputs show the values after the step being taken this cycle.
module alu_muldiv_iter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] prod_lo,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] part;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] opnd;
   logic             div_mode;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;

   // part is the product high half (multiply) or the partial remainder (divide);
   // shreg is the multiplier being shifted out or the dividend/quotient.
   always_comb begin
      mul_sum   = {1'b0, part} + (shreg[0] ? {1'b0, opnd} : '0);
      div_shift = {part, shreg[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, opnd};
      div_diff  = div_shift[WIDTH-1:0] - opnd;
      prod_hi   = mul_sum[WIDTH:1];
      prod_lo   = {mul_sum[0], shreg[WIDTH-1:1]};
      quotient  = {shreg[WIDTH-2:0], div_ge};
      remainder = div_ge ? div_diff : div_shift[WIDTH-1:0];
      done      = (count == CNT_W'(1));
   end

   // A zero divisor always passes the trial subtract, giving all-ones and the dividend.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         part     <= '0;
         shreg    <= '0;
         opnd     <= '0;
         div_mode <= 1'b0;
      end else if (start) begin
         count    <= CNT_W'(WIDTH);
         part     <= '0;
         div_mode <= op_div;
         shreg    <= op_div ? a : b;
         opnd     <= op_div ? b : a;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
         if (div_mode) begin
            part  <= remainder;
            shreg <= quotient;
         end else begin
            part  <= prod_hi;
            shreg <= prod_lo;
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: logic/add/sub/slt finish on the accept edge, mul/div/rem take WIDTH steps.
// Result and flags stay registered until the consumer takes them.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [2:0]       ALUControl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic             Carry,
   output logic             Overflow,
   output logic             DivZero
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [1:0]       state;
   logic [2:0]       op_q;
   logic             divz_q;
   logic             start;

   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   sub_full;
   logic             slt;
   logic [WIDTH-1:0] sc_result;
   logic             sc_carry;
   logic             sc_ovf;

   logic             it_done;
   logic [WIDTH-1:0] prod_lo;
   logic [WIDTH-1:0] prod_hi;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic [WIDTH-1:0] mc_result;
   logic             mc_carry;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign start     = in_ready && in_valid && is_multi(ALUControl);

   always_comb begin
      add_full  = {1'b0, SrcA} + {1'b0, SrcB};
      sub_full  = {1'b0, SrcA} + {1'b0, ~SrcB} + {{WIDTH{1'b0}}, 1'b1};
      slt       = $signed(SrcA) < $signed(SrcB);
      sc_result = '0;
      sc_carry  = 1'b0;
      sc_ovf    = 1'b0;
      case (ALUControl)
         OP_AND: sc_result = SrcA & SrcB;
         OP_OR:  sc_result = SrcA | SrcB;
         OP_ADD: begin
            sc_result = add_full[WIDTH-1:0];
            sc_carry  = add_full[WIDTH];
            sc_ovf    = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (add_full[WIDTH-1] != SrcA[WIDTH-1]);
         end
         OP_SUB: begin
            sc_result = sub_full[WIDTH-1:0];
            sc_carry  = sub_full[WIDTH];
            sc_ovf    = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (sub_full[WIDTH-1] != SrcA[WIDTH-1]);
         end
         OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, slt};
         default: sc_result = '0;
      endcase
   end

   always_comb begin
      mc_result = prod_lo;
      mc_carry  = 1'b0;
      case (op_q)
         OP_DIVU: mc_result = quotient;
         OP_REMU: mc_result = remainder;
         default: begin
            mc_result = prod_lo;
            mc_carry  = |prod_hi;
         end
      endcase
   end

   alu_muldiv_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op_div    (ALUControl != OP_MUL),
      .a         (SrcA),
      .b         (SrcB),
      .done      (it_done),
      .prod_lo   (prod_lo),
      .prod_hi   (prod_hi),
      .quotient  (quotient),
      .remainder (remainder)
   );

   // Operands are only looked at in IDLE; results change only on accept or final step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         op_q      <= OP_AND;
         divz_q    <= 1'b0;
         ALUResult <= '0;
         Zero      <= 1'b0;
         Carry     <= 1'b0;
         Overflow  <= 1'b0;
         DivZero   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_q <= ALUControl;
                  if (is_multi(ALUControl)) begin
                     divz_q <= (SrcB == '0) && (ALUControl != OP_MUL);
                     state  <= S_ITER;
                  end else begin
                     ALUResult <= sc_result;
                     Zero      <= (sc_result == '0);
                     Carry     <= sc_carry;
                     Overflow  <= sc_ovf;
                     DivZero   <= 1'b0;
                     state     <= S_DONE;
                  end
               end
            end
            S_ITER: begin
               if (it_done) begin
                  ALUResult <= mc_result;
                  Zero      <= (mc_result == '0);
                  Carry     <= mc_carry;
                  Overflow  <= 1'b0;
                  DivZero   <= divz_q;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a monitor compares every valid output against an arithmetic model,
// while the driver checks hand-computed literals for each vector.
module tb_seq_alu;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] SrcA = '0;
   logic [WIDTH-1:0] SrcB = '0;
   logic [2:0]       ALUControl = 3'b000;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] ALUResult;
   logic             Zero;
   logic             Carry;
   logic             Overflow;
   logic             DivZero;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   typedef struct {
      logic [7:0] res;
      logic       z;
      logic       c;
      logic       v;
      logic       dz;
      int         lat;
      int         acc_edge;
   } exp_t;

   exp_t exp_q[$];
   bit   seen = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   seq_alu #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .ALUControl (ALUControl),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ALUResult  (ALUResult),
      .Zero       (Zero),
      .Carry      (Carry),
      .Overflow   (Overflow),
      .DivZero    (DivZero)
   );

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Latency is counted in clock periods from the accept edge to the edge raising out_valid:
   // 0 for single-cycle ops (valid in the very next cycle), WIDTH for mul/div/rem.
   function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      int ua, ub, sa, sb, r, full;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      r  = 0;
      e.c = 1'b0; e.v = 1'b0; e.dz = 1'b0; e.lat = 0; e.acc_edge = 0;
      case (op)
         3'b000: r = ua & ub;
         3'b001: r = ua | ub;
         3'b010: begin
            full = ua + ub;
            r    = full % 256;
            e.c  = (full > 255);
            e.v  = (sa + sb > 127) || (sa + sb < -128);
         end
         3'b110: begin
            r   = (ua - ub + 256) % 256;
            e.c = (ua >= ub);
            e.v = (sa - sb > 127) || (sa - sb < -128);
         end
         3'b111: r = (sa < sb) ? 1 : 0;
         3'b011: begin
            full  = ua * ub;
            r     = full % 256;
            e.c   = (full > 255);
            e.lat = WIDTH;
         end
         3'b100: begin
            e.lat = WIDTH;
            if (ub == 0) begin r = 255; e.dz = 1'b1; end
            else r = ua / ub;
         end
         default: begin
            e.lat = WIDTH;
            if (ub == 0) begin r = ua; e.dz = 1'b1; end
            else r = ua % ub;
         end
      endcase
      e.res = 8'(r);
      e.z   = (r == 0);
      return e;
   endfunction

   // Compare process: sampled on the falling edge, well away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         exp_q.delete();
         seen = 1'b0;
      end else begin
         cmp("mon in_ready", in_ready, exp_q.size() == 0);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               cmp("mon spurious out_valid", out_valid, 1'b0);
            end else begin
               cmp("mon ALUResult", ALUResult, exp_q[0].res);
               cmp("mon Zero", Zero, exp_q[0].z);
               cmp("mon Carry", Carry, exp_q[0].c);
               cmp("mon Overflow", Overflow, exp_q[0].v);
               cmp("mon DivZero", DivZero, exp_q[0].dz);
               if (!seen) begin
                  cmp("mon latency", cyc - exp_q[0].acc_edge, exp_q[0].lat);
                  seen = 1'b1;
               end
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  seen = 1'b0;
               end
            end
         end
         if (in_valid && in_ready) begin
            e = model(ALUControl, SrcA, SrcB);
            e.acc_edge = cyc + 1;
            exp_q.push_back(e);
         end
      end
   end

   // Called just after a rising edge; returns just after the accept edge with operands scrambled.
   task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      bit got = 1'b0;
      ALUControl = op;
      SrcA       = a;
      SrcB       = b;
      in_valid   = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) cmp("accept timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      SrcA       = 8'($urandom);
      SrcB       = 8'($urandom);
      ALUControl = 3'($urandom);
   endtask

   task automatic waitResult(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) cmp("out_valid timeout", 32'd0, 32'd1);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] r, input logic z,
                              input logic c, input logic v, input logic dz);
      cmp({name, " result"}, ALUResult, r);
      cmp({name, " Zero"}, Zero, z);
      cmp({name, " Carry"}, Carry, c);
      cmp({name, " Overflow"}, Overflow, v);
      cmp({name, " DivZero"}, DivZero, dz);
   endtask

   task automatic runOp(input string name, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] r, input logic z,
                        input logic c, input logic v, input logic dz);
      bit ok;
      applyStimulus(op, a, b);
      waitResult(ok);
      if (ok) checkOutput(name, r, z, c, v, dz);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      exp_t e;
      bit   ok;

      $display("[TB] seq_alu directed test, WIDTH=%0d", WIDTH);
      repeat (2) @(posedge clk);
      #1;
      cmp("reset in_ready", in_ready, 1'b1);
      cmp("reset out_valid", out_valid, 1'b0);
      cmp("reset ALUResult", ALUResult, 8'h00);
      cmp("reset flags", {Zero, Carry, Overflow, DivZero}, 4'b0000);
      #2 rst_n = 1'b1;

      e = model(3'b010, 8'h7F, 8'h01);
      cmp("model add 7F+01", {e.res, e.z, e.c, e.v, e.dz}, {8'h80, 4'b0010});
      e = model(3'b011, 8'h10, 8'h11);
      cmp("model mul 10*11", {e.res, e.c}, {8'h10, 1'b1});
      e = model(3'b101, 8'h5A, 8'h00);
      cmp("model remu 5A/0", {e.res, e.dz}, {8'h5A, 1'b1});
      e = model(3'b110, 8'h80, 8'h01);
      cmp("model sub 80-01", {e.res, e.c, e.v}, {8'h7F, 2'b11});

      @(posedge clk);
      #1;
      //               name          op      A      B      R     Z     C     V     DZ
      runOp("ADD 7F+01",   3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
      runOp("SUB 05-05",   3'b110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      runOp("SLT 80,01",   3'b111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
      runOp("SLT 01,80",   3'b111, 8'h01, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      runOp("AND F0,3C",   3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
      runOp("OR F0,0F",    3'b001, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      runOp("ADD FF+01",   3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      runOp("SUB 00-01",   3'b110, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      runOp("SUB 80-01",   3'b110, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0);
      runOp("MUL 10*11",   3'b011, 8'h10, 8'h11, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0);
      runOp("MUL FF*FF",   3'b011, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
      runOp("DIVU C8/07",  3'b100, 8'hC8, 8'h07, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
      runOp("REMU C8/07",  3'b101, 8'hC8, 8'h07, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
      runOp("DIVU 07/C8",  3'b100, 8'h07, 8'hC8, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      runOp("DIVU 5A/00",  3'b100, 8'h5A, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
      runOp("REMU 5A/00",  3'b101, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);

      // Backpressure: hold the result while a new request waits at the input.
      out_ready = 1'b0;
      applyStimulus(3'b011, 8'h0F, 8'h03);
      waitResult(ok);
      if (ok) checkOutput("MUL 0F*03", 8'h2D, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      ALUControl = 3'b110;
      SrcA       = 8'h05;
      SrcB       = 8'h05;
      in_valid   = 1'b1;
      repeat (5) begin
         @(negedge clk);
         cmp("hold out_valid", out_valid, 1'b1);
         cmp("hold in_ready", in_ready, 1'b0);
         cmp("hold ALUResult", ALUResult, 8'h2D);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      cmp("release in_ready", in_ready, 1'b1);
      cmp("release out_valid", out_valid, 1'b0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      waitResult(ok);
      if (ok) checkOutput("queued SUB 05-05", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;

      // Asynchronous abort partway through a multiply.
      applyStimulus(3'b011, 8'h10, 8'h11);
      repeat (3) @(posedge clk);
      #1;
      cmp("mid-iter in_ready", in_ready, 1'b0);
      rst_n = 1'b0;
      #1;
      cmp("abort out_valid", out_valid, 1'b0);
      cmp("abort in_ready", in_ready, 1'b1);
      cmp("abort ALUResult", ALUResult, 8'h00);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      runOp("ADD 03+04",   3'b010, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
